matrix_result_serializer: RTL
=============================

# matrix_result_serializer

Downstream stage of `matrix_mul`. It captures one complete 4x4 result matrix `y` of 16-bit elements in a single handshake and streams it out one element per transfer, in row-major order, over a valid/ready interface. It also reports a running checksum of the matrix. It decouples the combinational multiplier from narrow consumers such as a UART formatter, a FIFO or a scoreboard.

## Interface
Parameters:
- `DIM`, default 4: matrix dimension, giving DIM x DIM elements.
- `ELEM_W`, default 16: element width, matching the `matrix_mul` output width.
- `SUM_W`, default 20: checksum width; ELEM_W + 2*log2(DIM).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_y` holds a valid matrix.
- `in_ready`  out  1  block can capture a matrix.
- `in_y`  in  DIM*DIM*ELEM_W  flattened matrix; element [i][j] at bits [(i*DIM+j)*ELEM_W +: ELEM_W].
- `out_valid`  out  1  `out_data`, `out_row`, `out_col` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the current element.
- `out_data`  out  ELEM_W  element value.
- `out_row`  out  log2(DIM)  row index of `out_data`.
- `out_col`  out  log2(DIM)  column index of `out_data`.
- `out_last`  out  1  current element is [DIM-1][DIM-1].
- `sum_valid`  out  1  one-cycle pulse; `sum_out` is valid.
- `sum_out`  out  SUM_W  unsigned sum of all DIM*DIM elements of the last matrix.

## Operation
- FSM states: IDLE, STREAM, SUM.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: register all DIM*DIM elements into an internal array, clear index to 0, clear accumulator to 0, go to STREAM.
- STREAM:
  - `in_ready`=0. `in_valid` is ignored and `in_y` may change freely without affecting the captured data.
  - `out_valid`=1. `out_data` = array[idx], with `out_row`=idx/DIM and `out_col`=idx%DIM.
  - Transfer occurs when `out_valid && out_ready`. On each transfer: accumulator += `out_data` (zero-extended to SUM_W) and idx increments.
  - Transfer at idx = DIM*DIM-1 (`out_last`=1): go to SUM.
- SUM:
  - Lasts exactly one cycle. `sum_valid`=1 and `sum_out` = accumulator, which includes the last element.
  - Go to IDLE.
- `sum_out` holds its value until the next capture clears the accumulator. It is stable in IDLE.
- Stall: while `out_valid && !out_ready`, all out_* outputs hold stable. `out_valid` never drops before its transfer.
- Arithmetic: unsigned throughout; no saturation. With SUM_W = 20 and DIM = 4 the accumulator cannot overflow, because 16*65535 < 2^20.
- Reset:
  - Asynchronous; takes effect immediately, including mid-stream.
  - Returns the FSM to IDLE. `in_ready`=1. `out_valid`, `out_last` and `sum_valid` = 0. `out_data`, `out_row`, `out_col`, `sum_out` and idx = 0. Array contents are don't-care.
  - The partially streamed matrix is discarded and no `sum_valid` is issued for it.

## Timing
- Capture edge N (`in_valid && in_ready` sampled high): `out_valid`=1 with element [0][0] from cycle N+1.
- With `out_ready` held high:
  - One element per cycle, cycles N+1..N+16.
  - `sum_valid` is high in cycle N+17.
  - `in_ready` rises in cycle N+18; the next capture can occur at the N+18 edge.
  - Throughput: 18 cycles per matrix.
- `in_ready` is a registered function of state only; no combinational path from `out_ready` to `in_ready`.
- `out_data` is driven from registered array and idx with no combinational dependence on `in_y`.
- Each `out_ready` deassertion adds exactly one cycle of latency per stalled cycle.

## Test plan
- Reset: assert `rst_n`=0 with `out_ready`=1, release, wait 3 cycles. Required: `in_ready`=1; `out_valid`=0; `sum_valid`=0; `sum_out`=0.
- Ramp matrix y[i][j] = i*4+j, `out_ready`=1:
  - 16 transfers with `out_data` 0..15 in order and (row,col) matching each index.
  - `out_last` high only on value 15.
  - `sum_valid` pulse with `sum_out`=120 one cycle after the last transfer.
- Max values (all elements 900 = 0x384, i.e. A and B all 15): `sum_out`=14400. All-0xFFFF matrix: `sum_out`=0xFFFF0 with no overflow.
- Backpressure on the ramp matrix:
  - Toggle `out_ready` 1,0,0,1,... randomly. Data order, indices and sum must be unchanged.
  - Outputs must be stable during every stalled cycle.
  - Drive a different `in_y` with `in_valid`=1 during STREAM; it must be ignored.
- Back-to-back: keep `in_valid`=1 with matrix A (sum 120), then matrix B (all 1, sum 16). Required: capture of B exactly at the cycle `in_ready` rises, with no lost or duplicated elements.
- Reset mid-operation: assert `rst_n` after the 7th transfer. Required: outputs immediately return to reset values, and no `sum_valid` is issued for that matrix. A fresh ramp matrix then streams correctly starting at [0][0] with `sum_out`=120.

Source files
------------

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures one DIM x DIM result matrix in a single handshake,
// streams it row-major over valid/ready, then pulses the unsigned checksum for one cycle.
module matrix_result_serializer #(
    parameter int DIM    = 4,
    parameter int ELEM_W = 16,
    parameter int SUM_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIM*DIM*ELEM_W-1:0] in_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_data,
    output logic [$clog2(DIM)-1:0]    out_row,
    output logic [$clog2(DIM)-1:0]    out_col,
    output logic                      out_last,
    output logic                      sum_valid,
    output logic [SUM_W-1:0]          sum_out
);

    localparam int NUM   = DIM * DIM;
    localparam int IDX_W = $clog2(NUM);
    localparam int RC_W  = $clog2(DIM);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] SUM    = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic [SUM_W-1:0]  acc;
    logic [ELEM_W-1:0] mem [NUM];

    logic capture;
    logic xfer;
    logic at_last;

    assign capture = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign at_last = (idx == IDX_W'(NUM - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == STREAM);
    // Gated so out_data reads zero outside STREAM even though the array is not reset.
    assign out_data  = out_valid ? mem[idx] : '0;
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = out_valid && at_last;
    assign sum_valid = (state == SUM);
    assign sum_out   = acc;

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                mem[k] <= in_y[k*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state <= STREAM;
                        idx   <= '0;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        acc <= acc + SUM_W'(out_data);
                        if (at_last) begin
                            state <= SUM;
                            idx   <= '0;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                            if (col == RC_W'(DIM - 1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                SUM: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
